// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants and fetch state encoding
//
// Purpose: opcode constants used by the decoder and immediate generator,
//          the NOP instruction word, and the fetch-stage state type.
// Ports:   none (package).

package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [2:0] {
    FETCH_IDLE  = 3'd0,
    FETCH_REQ   = 3'd1,
    FETCH_WAIT  = 3'd2,
    FETCH_HOLD  = 3'd3,
    FETCH_FAULT = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/next_pc_logic.sv
// rtl/next_pc_logic.sv - combinational next-PC selection and misalign detect
//
// Purpose: selects the PC following the presented instruction.
// Ports:
//   i_pc           current PC
//   i_imm32        sign-extended immediate of the current instruction
//   i_rs1_data     rs1 operand (jalr base)
//   i_branch_taken conditional branch resolved taken
//   i_jal          current instruction is jal
//   i_jalr         current instruction is jalr
//   o_next_pc      selected next PC
//   o_pc_plus4     i_pc + 4 (also the link value)
//   o_misaligned   o_next_pc is not word aligned

module next_pc_logic (
  input  logic [31:0] i_pc,
  input  logic [31:0] i_imm32,
  input  logic [31:0] i_rs1_data,
  input  logic        i_branch_taken,
  input  logic        i_jal,
  input  logic        i_jalr,
  output logic [31:0] o_next_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_misaligned
);

  logic [31:0] w_pc_plus_imm;
  logic [31:0] w_jalr_target;

  assign o_pc_plus4    = i_pc + 32'd4;
  assign w_pc_plus_imm = i_pc + i_imm32;
  // jalr clears bit 0 only; bit 1 can still be set and must raise a fault
  assign w_jalr_target = (i_rs1_data + i_imm32) & ~32'h1;

  // jalr beats jal, and any jump beats a taken branch
  always_comb begin
    o_next_pc = o_pc_plus4;
    if (i_jalr) begin
      o_next_pc = w_jalr_target;
    end else if (i_jal || i_branch_taken) begin
      o_next_pc = w_pc_plus_imm;
    end
  end

  assign o_misaligned = |o_next_pc[1:0];

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - RV32I fetch stage with req/ack instruction memory port
//
// Purpose: holds the PC, issues one-cycle word reads, presents one
//          instruction at a time, and advances the PC when it is retired.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   imem_req      one-cycle read request
//   imem_addr     word address pc[IMEM_AW+1:2]
//   imem_ack      read data valid (honoured only while waiting)
//   imem_rdata    instruction word with imem_ack
//   instruction   registered instruction to decoder
//   inst_valid    instruction and pc are valid
//   pc, pc_plus4  address of instruction and its link value
//   inst_ready    core retires the presented instruction
//   branch_taken, jal, jalr, imm32, rs1_data   next-PC controls
//   fetch_fault   sticky misaligned-target fault

module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instruction,
  output logic               inst_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  input  logic               inst_ready,
  input  logic               branch_taken,
  input  logic               jal,
  input  logic               jalr,
  input  logic [31:0]        imm32,
  input  logic [31:0]        rs1_data,
  output logic               fetch_fault
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instruction;
  logic         r_inst_valid;

  logic [31:0]  w_next_pc;
  logic         w_misaligned;

  next_pc_logic u_next_pc (
    .i_pc           (r_pc),
    .i_imm32        (imm32),
    .i_rs1_data     (rs1_data),
    .i_branch_taken (branch_taken),
    .i_jal          (jal),
    .i_jalr         (jalr),
    .o_next_pc      (w_next_pc),
    .o_pc_plus4     (pc_plus4),
    .o_misaligned   (w_misaligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= FETCH_IDLE;
      r_pc          <= RESET_PC;
      r_instruction <= NOP_INSN;
      r_inst_valid  <= 1'b0;
    end else begin
      case (r_state)
        FETCH_IDLE: r_state <= FETCH_REQ;
        FETCH_REQ:  r_state <= FETCH_WAIT;
        // Only WAIT listens to imem_ack, so stale acks after a reset are dropped
        FETCH_WAIT: begin
          if (imem_ack) begin
            r_instruction <= imem_rdata;
            r_inst_valid  <= 1'b1;
            r_state       <= FETCH_HOLD;
          end
        end
        FETCH_HOLD: begin
          if (inst_ready) begin
            r_pc         <= w_next_pc;
            r_inst_valid <= 1'b0;
            r_state      <= w_misaligned ? FETCH_FAULT : FETCH_REQ;
          end
        end
        FETCH_FAULT: r_state <= FETCH_FAULT;
        default:     r_state <= FETCH_IDLE;
      endcase
    end
  end

  assign imem_req    = (r_state == FETCH_REQ);
  assign fetch_fault = (r_state == FETCH_FAULT);
  assign imem_addr   = r_pc[IMEM_AW+1:2];
  assign pc          = r_pc;
  assign instruction = r_instruction;
  assign inst_valid  = r_inst_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch

module tb_instruction_fetch;

  localparam int          IMEM_AW  = 14;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic               imem_ack = 1'b0;
  logic [31:0]        imem_rdata = 32'h0;
  logic [31:0]        instruction;
  logic               inst_valid;
  logic [31:0]        pc;
  logic [31:0]        pc_plus4;
  logic               inst_ready = 1'b0;
  logic               branch_taken = 1'b0;
  logic               jal = 1'b0;
  logic               jalr = 1'b0;
  logic [31:0]        imm32 = 32'h0;
  logic [31:0]        rs1_data = 32'h0;
  logic               fetch_fault;

  instruction_fetch #(.RESET_PC(RESET_PC), .IMEM_AW(IMEM_AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .inst_valid   (inst_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .inst_ready   (inst_ready),
    .branch_taken (branch_taken),
    .jal          (jal),
    .jalr         (jalr),
    .imm32        (imm32),
    .rs1_data     (rs1_data),
    .fetch_fault  (fetch_fault)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_pc;
  bit          m_fault;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory contents depend only on the word index that survives aliasing.
  function automatic logic [31:0] mem_word(input logic [31:0] byte_addr);
    logic [13:0] w;
    w = byte_addr[15:2];
    return {2'b01, w, 2'b11, ~w};
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] imm,
                                           input logic [31:0] rs1, input logic j,
                                           input logic jr, input logic br);
    if (jr) return (rs1 + imm) & 32'hFFFF_FFFE;
    if (j || br) return cur + imm;
    return cur + 32'd4;
  endfunction

  task automatic clear_inputs();
    imem_ack = 1'b0; inst_ready = 1'b0; jal = 1'b0; jalr = 1'b0;
    branch_taken = 1'b0; imm32 = 32'h0; rs1_data = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    check("rst_pc", pc, RESET_PC);
    check("rst_insn", instruction, 32'h0000_0013);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_fault", {31'b0, fetch_fault}, 32'd0);
    check("rst_addr", {18'b0, imem_addr}, {18'b0, RESET_PC[15:2]});
    rst_n = 1'b1;
    tick();
    check("first_req", {31'b0, imem_req}, 32'd1);
    m_pc = RESET_PC;
    m_fault = 1'b0;
  endtask

  task automatic fetch(input int lat, input int hold, input logic j, input logic jr,
                       input logic br, input logic [31:0] imm, input logic [31:0] rs1);
    int          waited;
    logic [31:0] exp_insn;
    logic [31:0] nxt;
    waited = 0;
    while (!imem_req && waited < 8) begin
      tick();
      waited++;
    end
    check("req_seen", {31'b0, imem_req}, 32'd1);
    check("addr", {18'b0, imem_addr}, {18'b0, m_pc[15:2]});
    check("pc_at_req", pc, m_pc);
    check("valid_at_req", {31'b0, inst_valid}, 32'd0);
    exp_insn = mem_word(m_pc);
    tick();
    for (int k = 1; k < lat; k++) begin
      check("wait_no_req", {31'b0, imem_req}, 32'd0);
      check("wait_valid", {31'b0, inst_valid}, 32'd0);
      inst_ready = 1'($urandom_range(0, 1));
      jal = 1'($urandom_range(0, 1));
      jalr = 1'($urandom_range(0, 1));
      branch_taken = 1'($urandom_range(0, 1));
      imm32 = $urandom;
      rs1_data = $urandom;
      imem_rdata = $urandom;
      tick();
    end
    imem_ack = 1'b1;
    imem_rdata = exp_insn;
    tick();
    imem_ack = 1'b0;
    inst_ready = 1'b0;
    check("valid", {31'b0, inst_valid}, 32'd1);
    check("insn", instruction, exp_insn);
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    for (int k = 0; k < hold; k++) begin
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      jal = 1'($urandom_range(0, 1));
      jalr = 1'($urandom_range(0, 1));
      branch_taken = 1'($urandom_range(0, 1));
      imm32 = $urandom;
      rs1_data = $urandom;
      tick();
      check("hold_insn", instruction, exp_insn);
      check("hold_pc", pc, m_pc);
      check("hold_valid", {31'b0, inst_valid}, 32'd1);
      check("hold_no_req", {31'b0, imem_req}, 32'd0);
    end
    imem_ack = 1'b0;
    jal = j; jalr = jr; branch_taken = br; imm32 = imm; rs1_data = rs1;
    inst_ready = 1'b1;
    nxt = ref_next(m_pc, imm, rs1, j, jr, br);
    tick();
    clear_inputs();
    m_pc = nxt;
    m_fault = (nxt[1:0] != 2'b00);
    check("retire_valid", {31'b0, inst_valid}, 32'd0);
    check("next_pc", pc, nxt);
    check("fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    if (m_fault) begin
      for (int k = 0; k < 4; k++) begin
        inst_ready = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = $urandom;
        tick();
        check("fault_no_req", {31'b0, imem_req}, 32'd0);
        check("fault_sticky", {31'b0, fetch_fault}, 32'd1);
        check("fault_pc", pc, nxt);
        check("fault_valid", {31'b0, inst_valid}, 32'd0);
      end
      clear_inputs();
    end else begin
      check("req_after_retire", {31'b0, imem_req}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          kind;
    int          s;
    logic [31:0] imm_r;
    logic [31:0] rs1_r;

    do_reset();

    // back-to-back sequential fetches, 1-cycle ack
    for (int i = 0; i < 4; i++) fetch(1, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("seq_pc", m_pc, 32'h10);
    fetch(1, 0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0);
    check("branch_back", pc, 32'h08);
    fetch(1, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    fetch(1, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    fetch(1, 0, 1'b0, 1'b0, 1'b1, 32'h20, 32'h0);
    check("branch_fwd", pc, 32'h30);

    // slow memory and stalled consumer
    fetch(5, 4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // wrap at top of address space, then jal+jalr together
    fetch(2, 1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC - m_pc, 32'h0);
    check("top_pc", pc, 32'hFFFF_FFFC);
    fetch(1, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("wrap_pc", pc, 32'h0);
    fetch(1, 0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h200);
    check("jalr_wins", pc, 32'h240);

    // misaligned jalr target
    fetch(1, 0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h103);
    check("jalr_fault_pc", pc, 32'h106);

    // reset in WAIT followed by a stale ack
    do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    check("midrst_insn", instruction, 32'h0000_0013);
    tick();
    imem_ack = 1'b0;
    check("stale_insn", instruction, 32'h0000_0013);
    check("stale_valid", {31'b0, inst_valid}, 32'd0);
    check("stale_pc", pc, RESET_PC);
    m_pc = RESET_PC;
    fetch(1, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      s = $urandom_range(0, 128);
      imm_r = 32'((s - 64) * 4);
      rs1_r = $urandom & 32'hFFFF_FFFC;
      case (kind)
        5, 6: fetch($urandom_range(1, 4), $urandom_range(0, 3), 1'b0, 1'b0, 1'b1, imm_r, rs1_r);
        7:    fetch($urandom_range(1, 4), $urandom_range(0, 3), 1'b1, 1'b0,
                    1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, rs1_r);
        8:    fetch($urandom_range(1, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1,
                    1'($urandom_range(0, 1)), imm_r, rs1_r);
        9:    fetch($urandom_range(1, 4), $urandom_range(0, 3), 1'b0, 1'b1, 1'b0, $urandom, $urandom);
        default: fetch($urandom_range(1, 4), $urandom_range(0, 3), 1'b0, 1'b0, 1'b0, imm_r, rs1_r);
      endcase
      if (m_fault) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the RV32I core: holds the program counter, issues word reads to instruction memory over a request/acknowledge handshake, and presents one instruction at a time to the decoder and immediate generator. When the core retires the presented instruction, the stage computes the next PC from the sign-extended `imm32`, `rs1_data` and the branch/jump controls. It then fetches again.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `IMEM_AW`, 14, word-address width of instruction memory (byte address bits `[IMEM_AW+1:2]`).

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `imem_req`  out  1  one-cycle read request.
- `imem_addr`  out  IMEM_AW  word address, `pc[IMEM_AW+1:2]`.
- `imem_ack`  in  1  read data valid this cycle.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `instruction`  out  32  registered instruction to decoder / imm generator.
- `inst_valid`  out  1  `instruction` and `pc` are valid.
- `pc`  out  32  address of `instruction`.
- `pc_plus4`  out  32  `pc + 4` (link value for jal/jalr).
- `inst_ready`  in  1  core retires the presented instruction this cycle.
- `branch_taken`  in  1  conditional branch resolved taken.
- `jal`  in  1  current instruction is jal.
- `jalr`  in  1  current instruction is jalr.
- `imm32`  in  32  sign-extended immediate for current instruction.
- `rs1_data`  in  32  rs1 operand for jalr.
- `fetch_fault`  out  1  sticky misaligned-target fault.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, FAULT.
- Reset values:
  - state=IDLE, `pc`=RESET_PC, `instruction`=32'h0000_0013 (NOP).
  - `inst_valid`=0, `imem_req`=0, `fetch_fault`=0.
  - `imem_addr` always reflects `pc`.
- IDLE -> REQ unconditionally (one bubble after reset).
- REQ: `imem_req`=1 for exactly this cycle; -> WAIT.
- WAIT: on `imem_ack`, capture `imem_rdata` into `instruction`, set `inst_valid`=1; -> HOLD. Without ack, remain in WAIT (no timeout).
- HOLD: hold `instruction`/`pc` stable while `inst_ready`=0. When `inst_ready`=1, update `pc` to next_pc and clear `inst_valid`:
  - next_pc aligned -> REQ.
  - next_pc misaligned -> FAULT.
- next_pc priority:
  - `jalr`: `(rs1_data + imm32) & ~32'h1`.
  - else `jal` or `branch_taken`: `pc + imm32`.
  - else `pc + 4`.
- Arithmetic is 32-bit modulo; wrap from 32'hFFFF_FFFC to 0 is legal.
- Address bits above IMEM_AW+1 are dropped, so memory aliases.
- Misaligned: `next_pc[1:0] != 0`.
  - FAULT: `fetch_fault`=1, `pc`=faulting target, `inst_valid`=0, no requests.
  - FAULT exits only on reset.
- Control inputs are sampled only in HOLD with `inst_ready`=1; ignored otherwise.

## Timing
- REQ at cycle N. Earliest ack is N+1. `inst_valid` is high from N+2.
- Best-case throughput: one instruction per 3 cycles (REQ, WAIT, HOLD with `inst_ready`=1).
- `imem_ack` outside WAIT is ignored. This includes a stale ack arriving after a mid-fetch reset, which must not alter `instruction`.
- `inst_ready` while `inst_valid`=0 has no effect.
- Simultaneous `jal` and `jalr`: jalr wins. `branch_taken` with either jump: the jump wins.
- Reset asserted in any state returns all outputs to reset values at the next edge.

## Structure
- Shared package `riscv_pkg`:
  - opcode localparams, common with the immediate generator;
  - `NOP_INSN`;
  - fetch state enum.
- Sub-module `next_pc_logic`: purely combinational, computes next_pc and the misalign flag from `pc`, `imm32`, `rs1_data` and the controls.

## Test plan
- Reset, ack with 1-cycle latency, `inst_ready` held 1 -> `pc` sequence 0, 4, 8 every 3 cycles; `imem_addr` 0, 1, 2.
- Branch at `pc`=0x10 with `branch_taken`=1, `imm32`=-8 -> next `pc`=0x08. Same with `imm32`=+0x20 -> 0x30.
- jalr with `rs1_data`=0x103, `imm32`=0x4 -> `pc`=0x106 -> FAULT, `fetch_fault`=1, no further `imem_req`.
- Ack delayed 5 cycles and `inst_ready` held 0 for 4 cycles -> `instruction` and `pc` stable; exactly one `imem_req` per instruction.
- Reset asserted in WAIT, then stale `imem_ack` with 0xDEADBEEF -> `instruction` stays 0x00000013; fetch restarts at RESET_PC.
- `pc`=0xFFFF_FFFC sequential -> `pc`=0; jal and jalr together -> jalr target taken.
